vga_fb_arbiter: RTL and testbench

Single-port frame-buffer arbiter sitting between the VGA scan-out path and the pixel-writing engine. It shares one synchronous-read RAM between real-time display fetches, which have strict priority, and buffered writes from a valid/ready writer. A small write FIFO absorbs writer traffic while the display owns the RAM.

---
 rtl/vga_fb_arbiter.sv | 92 +++++++++
 tb/tb_vga_fb_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: display-priority arbiter sharing one sync-read frame-buffer RAM with a FIFO-buffered pixel writer.
// Ports: clk_in/rst (async, active-high); disp_req/disp_addr -> disp_data/disp_valid (3-cycle read latency);
// wr_valid/wr_addr/wr_data/wr_ready (write FIFO input); mem_addr/mem_we/mem_wdata/mem_rdata (registered RAM port);
// fifo_level (write FIFO occupancy).
module vga_fb_arbiter #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                         clk_in,
  input  logic                         rst,
  input  logic                         disp_req,
  input  logic [ADDR_W-1:0]            disp_addr,
  output logic [DATA_W-1:0]            disp_data,
  output logic                         disp_valid,
  input  logic                         wr_valid,
  input  logic [ADDR_W-1:0]            wr_addr,
  input  logic [DATA_W-1:0]            wr_data,
  output logic                         wr_ready,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic                         mem_we,
  output logic [DATA_W-1:0]            mem_wdata,
  input  logic [DATA_W-1:0]            mem_rdata,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_level
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);
  localparam logic [LW-1:0] FULL = LW'(DEPTH);
  logic [ADDR_W-1:0] fa_q [DEPTH];
  logic [DATA_W-1:0] fd_q [DEPTH];
  logic [PW-1:0]     wp_q, wp_d, rp_q, rp_d;
  logic [LW-1:0]     level_q, level_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d, disp_data_q, disp_data_d;
  logic              mem_we_q, mem_we_d, disp_valid_q, disp_valid_d;
  logic              tag0_q, tag0_d, tag1_q, tag1_d;
  logic              push, pop;
  // wr_ready depends only on registered level (and rst), so a pop in a full cycle cannot open a push.
  always_comb begin
    wr_ready    = (level_q != FULL) && !rst;
    push        = wr_valid && wr_ready;
    pop         = !disp_req && (level_q != '0);
    wp_d        = push ? wp_q + PW'(1) : wp_q;
    rp_d        = pop ? rp_q + PW'(1) : rp_q;
    level_d     = level_q + LW'(push) - LW'(pop);
    mem_addr_d  = disp_req ? disp_addr : pop ? fa_q[rp_q] : mem_addr_q;
    mem_wdata_d = pop ? fd_q[rp_q] : mem_wdata_q;
    mem_we_d    = pop;
    // Tag stage 0 marks the cycle mem_addr carries a display read; stage 1 the cycle its data is on mem_rdata.
    tag0_d       = disp_req;
    tag1_d       = tag0_q;
    disp_valid_d = tag1_q;
    disp_data_d  = tag1_q ? mem_rdata : disp_data_q;
  end
  always_ff @(posedge clk_in) begin
    if (push) begin
      fa_q[wp_q] <= wr_addr;
      fd_q[wp_q] <= wr_data;
    end
  end
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      wp_q         <= '0;
      rp_q         <= '0;
      level_q      <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_we_q     <= 1'b0;
      tag0_q       <= 1'b0;
      tag1_q       <= 1'b0;
      disp_valid_q <= 1'b0;
      disp_data_q  <= '0;
    end else begin
      wp_q         <= wp_d;
      rp_q         <= rp_d;
      level_q      <= level_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_we_q     <= mem_we_d;
      tag0_q       <= tag0_d;
      tag1_q       <= tag1_d;
      disp_valid_q <= disp_valid_d;
      disp_data_q  <= disp_data_d;
    end
  end
  assign mem_addr   = mem_addr_q;
  assign mem_we     = mem_we_q;
  assign mem_wdata  = mem_wdata_q;
  assign disp_data  = disp_data_q;
  assign disp_valid = disp_valid_q;
  assign fifo_level = level_q;
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb_vga_fb_arbiter: directed self-checking bench for vga_fb_arbiter with a behavioural sync-read RAM.
module tb_vga_fb_arbiter;
  logic        clk_in = 1'b0;
  logic        rst = 1'b1;
  logic        disp_req = 1'b0;
  logic [16:0] disp_addr = '0;
  logic [7:0]  disp_data;
  logic        disp_valid;
  logic        wr_valid = 1'b0;
  logic [16:0] wr_addr = '0;
  logic [7:0]  wr_data = '0;
  logic        wr_ready;
  logic [16:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = '0;
  logic [2:0]  fifo_level;
  int checks = 0;
  int failures = 0;
  logic [7:0]  ram [0:131071];
  logic [24:0] wlog [$];
  logic [24:0] exp_w [$];
  logic [7:0]  dlog [$];
  int max_level = 0;

  vga_fb_arbiter #(.ADDR_W(17), .DATA_W(8), .DEPTH(4)) dut (
    .clk_in(clk_in), .rst(rst), .disp_req(disp_req), .disp_addr(disp_addr),
    .disp_data(disp_data), .disp_valid(disp_valid), .wr_valid(wr_valid),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .fifo_level(fifo_level)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  always @(posedge clk_in) begin
    if (mem_we) wlog.push_back({mem_addr, mem_wdata});
    if (disp_valid) dlog.push_back(disp_data);
    if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
  end

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic drain(output int n);
    n = 0;
    while ((fifo_level != 0 || mem_we) && n < 40) begin
      step();
      n++;
    end
    step();
    step();
  endtask

  task automatic test_reset();
    #1;
    checks++; if (disp_data !== 8'h00) begin failures++; $display("FAIL reset_disp_data got=%h exp=00", disp_data); end
    checks++; if (disp_valid !== 1'b0) begin failures++; $display("FAIL reset_disp_valid got=%b exp=0", disp_valid); end
    checks++; if (mem_addr !== 17'h0) begin failures++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); end
    checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL reset_mem_we got=%b exp=0", mem_we); end
    checks++; if (mem_wdata !== 8'h00) begin failures++; $display("FAIL reset_mem_wdata got=%h exp=00", mem_wdata); end
    checks++; if (fifo_level !== 3'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", fifo_level); end
    checks++; if (wr_ready !== 1'b0) begin failures++; $display("FAIL reset_wr_ready got=%b exp=0", wr_ready); end
    step();
    rst = 1'b0;
    step();
    checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL release_wr_ready got=%b exp=1", wr_ready); end
  endtask

  task automatic test_reset_mid_run();
    int bad;
    for (int i = 0; i < 3; i++) begin
      disp_req = 1'b1; disp_addr = 17'h00700 + 17'(i);
      wr_valid = 1'b1; wr_addr = 17'h00600 + 17'(i); wr_data = 8'h60 + 8'(i);
      step();
    end
    checks++; if (fifo_level !== 3'd3) begin failures++; $display("FAIL midrst_queued got=%0d exp=3", fifo_level); end
    rst = 1'b1; disp_req = 1'b0; wr_valid = 1'b0;
    #1;
    wlog.delete(); dlog.delete();
    checks++; if ({disp_data, disp_valid, mem_addr, mem_we, mem_wdata} !== 35'h0) begin failures++; $display("FAIL midrst_outputs got=%h exp=0", {disp_data, disp_valid, mem_addr, mem_we, mem_wdata}); end
    checks++; if (fifo_level !== 3'd0) begin failures++; $display("FAIL midrst_level got=%0d exp=0", fifo_level); end
    checks++; if (wr_ready !== 1'b0) begin failures++; $display("FAIL midrst_wr_ready got=%b exp=0", wr_ready); end
    step(); step();
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (mem_we || disp_valid) bad++;
    end
    checks++; if (bad !== 0) begin failures++; $display("FAIL midrst_stale_activity got=%0d exp=0", bad); end
    checks++; if (wlog.size() !== 0 || dlog.size() !== 0) begin failures++; $display("FAIL midrst_logs got=%0d/%0d exp=0/0", wlog.size(), dlog.size()); end
    checks++; if (fifo_level !== 3'd0) begin failures++; $display("FAIL midrst_level_after got=%0d exp=0", fifo_level); end
  endtask

  task automatic test_write_drain();
    wlog.delete();
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1'b1; wr_addr = 17'h00010 + 17'(i); wr_data = 8'hA0 + 8'(i);
      step();
      checks++; if (mem_we !== (i > 0)) begin failures++; $display("FAIL drain_we c%0d got=%b exp=%b", i, mem_we, i > 0); end
      checks++; if (fifo_level !== 3'd1) begin failures++; $display("FAIL drain_level c%0d got=%0d exp=1", i, fifo_level); end
      if (i > 0) begin
        checks++; if ({mem_addr, mem_wdata} !== {17'h00010 + 17'(i-1), 8'hA0 + 8'(i-1)}) begin failures++; $display("FAIL drain_word c%0d got=%h/%h", i, mem_addr, mem_wdata); end
      end
    end
    wr_valid = 1'b0;
    step();
    checks++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 17'h00013, 8'hA3}) begin failures++; $display("FAIL drain_last got=%b/%h/%h exp=1/00013/a3", mem_we, mem_addr, mem_wdata); end
    checks++; if (fifo_level !== 3'd0) begin failures++; $display("FAIL drain_empty got=%0d exp=0", fifo_level); end
    step();
    checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL drain_we_off got=%b exp=0", mem_we); end
  endtask

  task automatic test_display_priority();
    int j, n;
    j = 0; wlog.delete(); dlog.delete();
    for (int c = 0; c < 10; c++) begin
      disp_req = 1'b1; disp_addr = 17'h00300 + 17'(c);
      wr_valid = 1'b1; wr_addr = 17'h00200 + 17'(j); wr_data = 8'hC0 + 8'(j);
      #1;
      checks++; if (wr_ready !== (c < 4)) begin failures++; $display("FAIL prio_wr_ready c%0d got=%b exp=%b", c, wr_ready, c < 4); end
      if (wr_ready) j++;
      step();
      checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL prio_mem_we c%0d got=%b exp=0", c, mem_we); end
    end
    checks++; if (j !== 4) begin failures++; $display("FAIL prio_accepted got=%0d exp=4", j); end
    disp_req = 1'b0;
    n = 0;
    while (j < 6 && n < 10) begin
      wr_valid = 1'b1; wr_addr = 17'h00200 + 17'(j); wr_data = 8'hC0 + 8'(j);
      #1;
      if (n == 0) begin
        checks++; if (wr_ready !== 1'b0) begin failures++; $display("FAIL prio_full_release got=%b exp=0", wr_ready); end
      end
      if (wr_ready) j++;
      step();
      n++;
    end
    wr_valid = 1'b0;
    drain(n);
    checks++; if (n >= 40) begin failures++; $display("FAIL prio_drain_timeout got=%0d exp<40", n); end
    checks++; if (wlog.size() !== 6) begin failures++; $display("FAIL prio_wcount got=%0d exp=6", wlog.size()); end
    for (int i = 0; i < 6 && i < wlog.size(); i++) begin
      checks++; if (wlog[i] !== {17'h00200 + 17'(i), 8'hC0 + 8'(i)}) begin failures++; $display("FAIL prio_order w%0d got=%h", i, wlog[i]); end
    end
    checks++; if (dlog.size() !== 10) begin failures++; $display("FAIL prio_reads got=%0d exp=10", dlog.size()); end
    for (int i = 0; i < 10 && i < dlog.size(); i++) begin
      checks++; if (dlog[i] !== (8'(i) ^ 8'h3C)) begin failures++; $display("FAIL prio_rdata r%0d got=%h exp=%h", i, dlog[i], 8'(i) ^ 8'h3C); end
    end
  endtask

  task automatic test_read_latency();
    int n;
    wr_valid = 1'b1; wr_addr = 17'h00100; wr_data = 8'h5A;
    step();
    wr_valid = 1'b0;
    drain(n);
    checks++; if (n >= 40) begin failures++; $display("FAIL lat_drain_timeout got=%0d exp<40", n); end
    disp_req = 1'b1; disp_addr = 17'h00100;
    step();
    disp_req = 1'b0;
    checks++; if ({mem_addr, mem_we} !== {17'h00100, 1'b0}) begin failures++; $display("FAIL lat_mem_addr got=%h/%b exp=00100/0", mem_addr, mem_we); end
    for (int c = 1; c <= 4; c++) begin
      checks++; if (disp_valid !== (c == 3)) begin failures++; $display("FAIL lat_valid c%0d got=%b exp=%b", c, disp_valid, c == 3); end
      if (c == 3) begin
        checks++; if (disp_data !== 8'h5A) begin failures++; $display("FAIL lat_data got=%h exp=5a", disp_data); end
      end
      step();
    end
  endtask

  task automatic test_full_boundary();
    int n;
    wlog.delete();
    for (int j = 0; j < 4; j++) begin
      disp_req = 1'b1; disp_addr = 17'h00500;
      wr_valid = 1'b1; wr_addr = 17'h00400 + 17'(j); wr_data = 8'hE0 + 8'(j);
      step();
    end
    disp_req = 1'b0; wr_addr = 17'h00404; wr_data = 8'hE4;
    #1;
    checks++; if ({fifo_level, wr_ready} !== {3'd4, 1'b0}) begin failures++; $display("FAIL full_pre got=%0d/%b exp=4/0", fifo_level, wr_ready); end
    step();
    checks++; if ({fifo_level, mem_we, mem_addr} !== {3'd3, 1'b1, 17'h00400}) begin failures++; $display("FAIL full_pop got=%0d/%b/%h exp=3/1/00400", fifo_level, mem_we, mem_addr); end
    disp_req = 1'b1;
    #1;
    checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL full_reopen got=%b exp=1", wr_ready); end
    step();
    checks++; if ({fifo_level, mem_we} !== {3'd4, 1'b0}) begin failures++; $display("FAIL full_end got=%0d/%b exp=4/0", fifo_level, mem_we); end
    disp_req = 1'b0; wr_valid = 1'b0;
    drain(n);
    checks++; if (n >= 40) begin failures++; $display("FAIL full_drain_timeout got=%0d exp<40", n); end
    checks++; if (wlog.size() !== 5) begin failures++; $display("FAIL full_wcount got=%0d exp=5", wlog.size()); end
    for (int i = 0; i < 5 && i < wlog.size(); i++) begin
      checks++; if (wlog[i] !== {17'h00400 + 17'(i), 8'hE0 + 8'(i)}) begin failures++; $display("FAIL full_order w%0d got=%h", i, wlog[i]); end
    end
  endtask

  task automatic test_pixel_cadence();
    int n, bad;
    logic acc;
    logic [7:0] sb [int];
    wlog.delete(); dlog.delete(); exp_w.delete(); max_level = 0;
    wr_addr = 17'h02000 + 17'($urandom_range(0, 255)); wr_data = 8'($urandom);
    for (int i = 0; i < 128; i++) begin
      disp_req = (i % 2 == 0); disp_addr = 17'h01000 + 17'(i / 2);
      wr_valid = 1'b1;
      #1;
      acc = wr_ready;
      step();
      if (acc) begin
        exp_w.push_back({wr_addr, wr_data});
        wr_addr = 17'h02000 + 17'($urandom_range(0, 255)); wr_data = 8'($urandom);
      end
    end
    disp_req = 1'b0; wr_valid = 1'b0;
    drain(n);
    checks++; if (n >= 40) begin failures++; $display("FAIL pix_drain_timeout got=%0d exp<40", n); end
    checks++; if (dlog.size() !== 64) begin failures++; $display("FAIL pix_reads got=%0d exp=64", dlog.size()); end
    bad = 0;
    for (int i = 0; i < 64 && i < dlog.size(); i++) if (dlog[i] !== (8'(i) ^ 8'h3C)) bad++;
    checks++; if (bad !== 0) begin failures++; $display("FAIL pix_read_order bad=%0d exp=0", bad); end
    checks++; if (max_level > 4) begin failures++; $display("FAIL pix_max_level got=%0d exp<=4", max_level); end
    checks++; if (exp_w.size() < 64) begin failures++; $display("FAIL pix_write_rate got=%0d exp>=64", exp_w.size()); end
    checks++; if (wlog.size() !== exp_w.size()) begin failures++; $display("FAIL pix_wcount got=%0d exp=%0d", wlog.size(), exp_w.size()); end
    bad = 0;
    for (int i = 0; i < exp_w.size() && i < wlog.size(); i++) if (wlog[i] !== exp_w[i]) bad++;
    checks++; if (bad !== 0) begin failures++; $display("FAIL pix_write_order bad=%0d exp=0", bad); end
    foreach (exp_w[i]) sb[int'(exp_w[i][24:8])] = exp_w[i][7:0];
    bad = 0;
    foreach (sb[a]) if (ram[a] !== sb[a]) bad++;
    checks++; if (bad !== 0) begin failures++; $display("FAIL pix_ram_scoreboard bad=%0d exp=0", bad); end
  endtask

  initial begin
    for (int a = 0; a < 131072; a++) ram[a] = 8'(a) ^ 8'h3C;
    test_reset();
    test_reset_mid_run();
    test_write_drain();
    test_display_priority();
    test_read_latency();
    test_full_boundary();
    test_pixel_cadence();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
